// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The design-wide defines are normally provided globally; the guards keep this slice self-contained.
`ifndef ysyx_22040931_PHC_RUN
`define ysyx_22040931_PHC_RUN 1'b0
`endif
`ifndef ysyx_22040931_PHC_REDIR_PEND
`define ysyx_22040931_PHC_REDIR_PEND 1'b1
`endif
`ifndef ysyx_22040931_ZERO_PC
`define ysyx_22040931_ZERO_PC 64'h0
`endif
`ifndef ysyx_22040931_REG_BUS
`define ysyx_22040931_REG_BUS 63:0
`endif

package pipe_hazard_ctrl_pkg;

    localparam int PHC_PC_W = 64;
    localparam int PHC_RA_W = 5;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
    } stall_t;

    typedef struct packed {
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
    } flush_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in (i_*), stall/flush/redirect controls out (o_*).
// slave = controller side, master = pipeline side.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PC_W = PHC_PC_W,
    parameter int RA_W = PHC_RA_W
);
    logic            i_ifu_busy;
    logic            i_ex_busy;
    logic            i_lsu_busy;
    logic [RA_W-1:0] i_id_rs1;
    logic [RA_W-1:0] i_id_rs2;
    logic            i_id_rs1_used;
    logic            i_id_rs2_used;
    logic            i_ex_is_load;
    logic [RA_W-1:0] i_ex_rd;
    logic            i_ex_redirect;
    logic [PC_W-1:0] i_ex_target;
    logic            i_wb_trap;
    logic [PC_W-1:0] i_wb_trap_pc;

    logic            o_stall_if;
    logic            o_stall_id;
    logic            o_stall_ex;
    logic            o_stall_mem;
    logic            o_flush_id;
    logic            o_flush_ex;
    logic            o_flush_mem;
    logic            o_redirect_valid;
    logic [PC_W-1:0] o_redirect_pc;

    modport slave (
        input  i_ifu_busy, i_ex_busy, i_lsu_busy,
        input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
        input  i_ex_is_load, i_ex_rd, i_ex_redirect, i_ex_target,
        input  i_wb_trap, i_wb_trap_pc,
        output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
        output o_flush_id, o_flush_ex, o_flush_mem,
        output o_redirect_valid, o_redirect_pc
    );

    modport master (
        output i_ifu_busy, i_ex_busy, i_lsu_busy,
        output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
        output i_ex_is_load, i_ex_rd, i_ex_redirect, i_ex_target,
        output i_wb_trap, i_wb_trap_pc,
        input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
        input  o_flush_id, o_flush_ex, o_flush_mem,
        input  o_redirect_valid, o_redirect_pc
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose rd feeds a used ID source; x0 never matches.
// Purely combinational, no state, no backpressure of its own.
module pipe_hazard_ctrl_hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic            i_id_rs1_used,
    input  logic            i_id_rs2_used,
    input  logic            i_ex_is_load,
    input  logic [RA_W-1:0] i_ex_rd,
    output logic            o_load_use
);
    logic w_rd_nz;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nz    = |i_ex_rd;
    assign w_hit_rs1  = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2  = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_ex_is_load & w_rd_nz & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline; controls are same-cycle combinational,
// a redirect IF cannot take is parked in REDIR_PEND. Perf counters: YSYX_22040931_PIPE_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PC_W = PHC_PC_W,
    parameter int RA_W = PHC_RA_W
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
`ifdef YSYX_22040931_PIPE_PERF_EN
    ,
    output logic [63:0]        o_perf_stall_cyc,
    output logic [63:0]        o_perf_lu_cnt,
    output logic [63:0]        o_perf_flush_cnt
`endif
);
    localparam logic [0:0]      S_RUN   = `ysyx_22040931_PHC_RUN;
    localparam logic [0:0]      S_PEND  = `ysyx_22040931_PHC_REDIR_PEND;
    localparam logic [PC_W-1:0] PC_ZERO = PC_W'(`ysyx_22040931_ZERO_PC);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [PC_W-1:0] r_pend_pc;
    logic [PC_W-1:0] w_pend_pc_nxt;

    logic            w_load_use;
    logic            w_pend;
    logic            w_trap;
    logic            w_ex_stall;
    logic            w_redir_acc;
    logic            w_lu_eff;
    logic            w_accept;
    logic            w_deliver;
    logic [PC_W-1:0] w_src_pc;
    logic [PC_W-1:0] w_tgt_pc;
    stall_t          w_stall;
    flush_t          w_flush;

    pipe_hazard_ctrl_hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard_detect (
        .i_id_rs1      (hz.i_id_rs1),
        .i_id_rs2      (hz.i_id_rs2),
        .i_id_rs1_used (hz.i_id_rs1_used),
        .i_id_rs2_used (hz.i_id_rs2_used),
        .i_ex_is_load  (hz.i_ex_is_load),
        .i_ex_rd       (hz.i_ex_rd),
        .o_load_use    (w_load_use)
    );

    assign w_pend     = (r_state == S_PEND);
    assign w_trap     = hz.i_wb_trap;
    assign w_ex_stall = hz.i_lsu_busy | hz.i_ex_busy;

    // While pending, EX already holds a bubble, so any ex_redirect seen there is stale.
    assign w_redir_acc = hz.i_ex_redirect & ~w_ex_stall & ~w_pend & ~w_trap;
    assign w_lu_eff    = w_load_use & ~w_redir_acc & ~w_trap;
    assign w_accept    = w_trap | w_redir_acc;
    assign w_src_pc    = w_trap ? hz.i_wb_trap_pc : hz.i_ex_target;
    assign w_tgt_pc    = w_accept ? w_src_pc : r_pend_pc;
    assign w_deliver   = (w_accept | w_pend) & ~hz.i_ifu_busy;

    always_comb begin
        w_stall.stall_mem = hz.i_lsu_busy;
        w_stall.stall_ex  = w_ex_stall;
        w_stall.stall_id  = w_ex_stall | w_lu_eff;
        w_stall.stall_if  = w_ex_stall | w_lu_eff | hz.i_ifu_busy | w_pend;
        w_flush.flush_mem = 1'b0;
        w_flush.flush_ex  = (w_lu_eff & ~w_ex_stall) | w_redir_acc;
        w_flush.flush_id  = w_redir_acc | w_pend;
        // A trap drains everything younger; only an in-flight data access keeps mem_wb held.
        if (w_trap) begin
            w_stall.stall_if = 1'b0;
            w_stall.stall_id = 1'b0;
            w_stall.stall_ex = 1'b0;
            w_flush          = '1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_pc_nxt = r_pend_pc;
        if (w_accept | w_pend) begin
            if (hz.i_ifu_busy) begin
                w_state_nxt   = S_PEND;
                w_pend_pc_nxt = w_tgt_pc;
            end else begin
                w_state_nxt   = S_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_pend_pc <= PC_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    // Reset forces a safe pattern on the pipeline regardless of current inputs.
    assign hz.o_stall_if       = reset & w_stall.stall_if;
    assign hz.o_stall_id       = reset & w_stall.stall_id;
    assign hz.o_stall_ex       = reset & w_stall.stall_ex;
    assign hz.o_stall_mem      = reset & w_stall.stall_mem;
    assign hz.o_flush_id       = ~reset | w_flush.flush_id;
    assign hz.o_flush_ex       = ~reset | w_flush.flush_ex;
    assign hz.o_flush_mem      = ~reset | w_flush.flush_mem;
    assign hz.o_redirect_valid = reset & w_deliver;
    assign hz.o_redirect_pc    = (reset & w_deliver) ? w_tgt_pc : PC_ZERO;

`ifdef YSYX_22040931_PIPE_PERF_EN
    logic [63:0] r_perf_stall_cyc;
    logic [63:0] r_perf_lu_cnt;
    logic [63:0] r_perf_flush_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_stall_cyc <= '0;
            r_perf_lu_cnt    <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            r_perf_stall_cyc <= r_perf_stall_cyc + {63'd0, w_stall.stall_id};
            r_perf_lu_cnt    <= r_perf_lu_cnt + {63'd0, w_lu_eff};
            r_perf_flush_cnt <= r_perf_flush_cnt + {63'd0, w_accept};
        end
    end

    assign o_perf_stall_cyc = r_perf_stall_cyc;
    assign o_perf_lu_cnt    = r_perf_lu_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences, then random traffic vs a reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        logic       ifu_busy, ex_busy, lsu_busy;
        logic [4:0] rs1, rs2;
        logic       rs1_used, rs2_used, ex_is_load;
        logic [4:0] ex_rd;
        logic       ex_redirect;
        logic [63:0] ex_target;
        logic       wb_trap;
        logic [63:0] wb_trap_pc;
    } in_t;

    typedef struct {
        logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, rv;
        logic [63:0] rpc;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    bit          m_pend    = 1'b0;
    logic [63:0] m_pend_pc = 64'h0;

    localparam logic [63:0] TGT_A = 64'h0000_0000_8000_0100;
    localparam logic [63:0] TRAP  = 64'h0000_0000_8000_0004;
    localparam logic [63:0] TGT_C = 64'h0000_0000_8000_0200;

    // flags = {ifu_busy, ex_busy, lsu_busy}, used = {rs1_used, rs2_used}
    function automatic in_t mk_in(logic [2:0] busy, logic [4:0] rs1, logic [4:0] rs2, logic [1:0] used,
                                  logic ld, logic [4:0] rd, logic redir, logic [63:0] tgt,
                                  logic trap, logic [63:0] tpc);
        in_t v;
        {v.ifu_busy, v.ex_busy, v.lsu_busy} = busy;
        v.rs1 = rs1; v.rs2 = rs2;
        {v.rs1_used, v.rs2_used} = used;
        v.ex_is_load = ld; v.ex_rd = rd;
        v.ex_redirect = redir; v.ex_target = tgt;
        v.wb_trap = trap; v.wb_trap_pc = tpc;
        return v;
    endfunction

    // flags = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, redirect_valid}
    function automatic out_t mk_out(logic [7:0] f, logic [63:0] rpc);
        out_t o;
        {o.s_if, o.s_id, o.s_ex, o.s_mem, o.f_id, o.f_ex, o.f_mem, o.rv} = f;
        o.rpc = rpc;
        return o;
    endfunction

    // Reference behaviour from the controller rules: priority trap > redirect > load-use,
    // plus a one-entry "redirect owed to IF" slot.
    function automatic out_t model(in_t v, bit pend, logic [63:0] ppc,
                                   output bit npend, output logic [63:0] nppc);
        out_t        o;
        bit          lu, exs, taken;
        logic [63:0] tgt;
        o   = mk_out(8'h00, 64'h0);
        lu  = v.ex_is_load && (v.ex_rd != 5'd0) &&
              ((v.rs1_used && v.rs1 == v.ex_rd) || (v.rs2_used && v.rs2 == v.ex_rd));
        exs = v.lsu_busy || v.ex_busy;
        o.s_mem = v.lsu_busy;
        taken = 1'b0;
        tgt   = ppc;
        if (v.wb_trap) begin
            o.f_id = 1'b1; o.f_ex = 1'b1; o.f_mem = 1'b1;
            taken = 1'b1; tgt = v.wb_trap_pc;
        end else if (!pend && v.ex_redirect && !exs) begin
            o.f_id = 1'b1; o.f_ex = 1'b1;
            o.s_if = v.ifu_busy;
            taken = 1'b1; tgt = v.ex_target;
        end else begin
            o.s_ex = exs;
            o.s_id = exs || lu;
            o.s_if = exs || lu || v.ifu_busy || pend;
            o.f_ex = lu && !exs;
            o.f_id = pend;
        end
        npend = 1'b0;
        nppc  = ppc;
        if (taken || pend) begin
            if (v.ifu_busy) begin
                npend = 1'b1;
                nppc  = tgt;
            end else begin
                o.rv  = 1'b1;
                o.rpc = tgt;
            end
        end
        return o;
    endfunction

    task automatic drive(input in_t v);
        hz.i_ifu_busy    = v.ifu_busy;
        hz.i_ex_busy     = v.ex_busy;
        hz.i_lsu_busy    = v.lsu_busy;
        hz.i_id_rs1      = v.rs1;
        hz.i_id_rs2      = v.rs2;
        hz.i_id_rs1_used = v.rs1_used;
        hz.i_id_rs2_used = v.rs2_used;
        hz.i_ex_is_load  = v.ex_is_load;
        hz.i_ex_rd       = v.ex_rd;
        hz.i_ex_redirect = v.ex_redirect;
        hz.i_ex_target   = v.ex_target;
        hz.i_wb_trap     = v.wb_trap;
        hz.i_wb_trap_pc  = v.wb_trap_pc;
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", n, a, e);
        end
    endtask

    task automatic chk64(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic compare(input string tag, input out_t e);
        chk1 ({tag, ".stall_if"},       hz.o_stall_if,       e.s_if);
        chk1 ({tag, ".stall_id"},       hz.o_stall_id,       e.s_id);
        chk1 ({tag, ".stall_ex"},       hz.o_stall_ex,       e.s_ex);
        chk1 ({tag, ".stall_mem"},      hz.o_stall_mem,      e.s_mem);
        chk1 ({tag, ".flush_id"},       hz.o_flush_id,       e.f_id);
        chk1 ({tag, ".flush_ex"},       hz.o_flush_ex,       e.f_ex);
        chk1 ({tag, ".flush_mem"},      hz.o_flush_mem,      e.f_mem);
        chk1 ({tag, ".redirect_valid"}, hz.o_redirect_valid, e.rv);
        chk64({tag, ".redirect_pc"},    hz.o_redirect_pc,    e.rpc);
    endtask

    // One clock cycle: drive after the edge, sample before the next one, then advance the model.
    task automatic run_vec(input in_t v, input out_t e, input string tag);
        bit          np;
        logic [63:0] npc;
        out_t        unused_o;
        @(posedge clock);
        #1;
        drive(v);
        #3;
        compare(tag, e);
        unused_o  = model(v, m_pend, m_pend_pc, np, npc);
        m_pend    = np;
        m_pend_pc = npc;
    endtask

    task automatic run_model(input in_t v, input string tag);
        bit          np;
        logic [63:0] npc;
        out_t        e;
        e = model(v, m_pend, m_pend_pc, np, npc);
        run_vec(v, e, tag);
    endtask

    vec_t tbl[$];
    in_t  idle, busy_if, v;
    out_t zero_o, rst_o;

    initial begin
        idle    = mk_in(3'b000, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0, 64'h0);
        busy_if = mk_in(3'b100, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0, 64'h0);
        zero_o  = mk_out(8'b0000_0000, 64'h0);
        rst_o   = mk_out(8'b0000_1110, 64'h0);

        tbl.push_back('{"idle",       idle, zero_o});
        tbl.push_back('{"lu_rs1",     mk_in(3'b000, 5'd5, 5'd0, 2'b10, 1'b1, 5'd5, 1'b0, 64'h0, 1'b0, 64'h0), mk_out(8'b1100_0100, 64'h0)});
        tbl.push_back('{"lu_bubble",  mk_in(3'b000, 5'd5, 5'd0, 2'b10, 1'b0, 5'd5, 1'b0, 64'h0, 1'b0, 64'h0), zero_o});
        tbl.push_back('{"lu_x0",      mk_in(3'b000, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 64'h0, 1'b0, 64'h0), zero_o});
        tbl.push_back('{"rs2_unused", mk_in(3'b000, 5'd3, 5'd7, 2'b10, 1'b1, 5'd7, 1'b0, 64'h0, 1'b0, 64'h0), zero_o});
        tbl.push_back('{"lu_rs2",     mk_in(3'b000, 5'd3, 5'd7, 2'b01, 1'b1, 5'd7, 1'b0, 64'h0, 1'b0, 64'h0), mk_out(8'b1100_0100, 64'h0)});
        tbl.push_back('{"redirect",   mk_in(3'b000, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_A, 1'b0, 64'h0), mk_out(8'b0000_1101, TGT_A)});
        tbl.push_back('{"trap_redir", mk_in(3'b000, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_A, 1'b1, TRAP),  mk_out(8'b0000_1111, TRAP)});
        tbl.push_back('{"lsu_lu",     mk_in(3'b001, 5'd5, 5'd0, 2'b10, 1'b1, 5'd5, 1'b0, 64'h0, 1'b0, 64'h0), mk_out(8'b1111_0000, 64'h0)});
        tbl.push_back('{"exb_redir",  mk_in(3'b010, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_A, 1'b0, 64'h0), mk_out(8'b1110_0000, 64'h0)});
        tbl.push_back('{"trap_lsu",   mk_in(3'b001, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 64'h0, 1'b1, TRAP),  mk_out(8'b0001_1111, TRAP)});
        tbl.push_back('{"redir_lu",   mk_in(3'b000, 5'd5, 5'd0, 2'b10, 1'b1, 5'd5, 1'b1, TGT_A, 1'b0, 64'h0), mk_out(8'b0000_1101, TGT_A)});
        tbl.push_back('{"ifu_busy",   busy_if, mk_out(8'b1000_0000, 64'h0)});
        tbl.push_back('{"exb_lu",     mk_in(3'b010, 5'd5, 5'd0, 2'b10, 1'b1, 5'd5, 1'b0, 64'h0, 1'b0, 64'h0), mk_out(8'b1110_0000, 64'h0)});

        // Reset state, sampled while reset is held
        reset = 1'b0;
        drive(idle);
        #2;
        compare("rst0", rst_o);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[k]) run_vec(tbl[k].i, tbl[k].o, tbl[k].name);

        // Redirect while IF busy for 3 cycles, delivered on cycle 4
        run_vec(mk_in(3'b100, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_A, 1'b0, 64'h0), mk_out(8'b1000_1100, 64'h0), "pend_c1");
        run_vec(busy_if, mk_out(8'b1000_1000, 64'h0), "pend_c2");
        run_vec(busy_if, mk_out(8'b1000_1000, 64'h0), "pend_c3");
        run_vec(idle,    mk_out(8'b1000_1001, TGT_A), "pend_c4");
        run_vec(idle,    zero_o, "pend_c5");

        // Trap overwrites a pending redirect; a stale ex_redirect while pending is ignored
        run_vec(mk_in(3'b100, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_A, 1'b0, 64'h0), mk_out(8'b1000_1100, 64'h0), "ovr_c1");
        run_vec(mk_in(3'b100, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 64'h0, 1'b1, TRAP),  mk_out(8'b0000_1110, 64'h0), "ovr_c2");
        run_vec(mk_in(3'b000, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_C, 1'b0, 64'h0), mk_out(8'b1000_1001, TRAP),  "ovr_c3");
        run_vec(idle, zero_o, "ovr_c4");

        // LSU busy for 5 cycles with a load-use pending: everything held, no bubble
        for (int c = 0; c < 5; c++)
            run_vec(mk_in(3'b001, 5'd5, 5'd0, 2'b10, 1'b1, 5'd5, 1'b0, 64'h0, 1'b0, 64'h0),
                    mk_out(8'b1111_0000, 64'h0), $sformatf("lsu_lu_%0d", c));
        run_vec(mk_in(3'b000, 5'd5, 5'd0, 2'b10, 1'b1, 5'd5, 1'b0, 64'h0, 1'b0, 64'h0), mk_out(8'b1100_0100, 64'h0), "lsu_lu_rel");

        // Reset asserted mid-REDIR_PEND discards the pending PC
        run_vec(mk_in(3'b100, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, TGT_A, 1'b0, 64'h0), mk_out(8'b1000_1100, 64'h0), "rstp_c1");
        run_vec(busy_if, mk_out(8'b1000_1000, 64'h0), "rstp_c2");
        #2;
        reset = 1'b0;
        #1;
        compare("rstp_async", rst_o);
        m_pend    = 1'b0;
        m_pend_pc = 64'h0;
        @(negedge clock);
        reset = 1'b1;
        run_vec(idle, zero_o, "rstp_after1");
        run_vec(idle, zero_o, "rstp_after2");

        // Random traffic with a small register space so load-use hits are frequent
        for (int n = 0; n < 600; n++) begin
            v.ifu_busy    = ($urandom_range(0, 2) == 0);
            v.ex_busy     = ($urandom_range(0, 4) == 0);
            v.lsu_busy    = ($urandom_range(0, 4) == 0);
            v.rs1         = 5'($urandom_range(0, 3));
            v.rs2         = 5'($urandom_range(0, 3));
            v.rs1_used    = 1'($urandom_range(0, 1));
            v.rs2_used    = 1'($urandom_range(0, 1));
            v.ex_is_load  = ($urandom_range(0, 2) == 0);
            v.ex_rd       = 5'($urandom_range(0, 3));
            v.ex_redirect = ($urandom_range(0, 3) == 0);
            v.ex_target   = {$urandom, $urandom};
            v.wb_trap     = ($urandom_range(0, 9) == 0);
            v.wb_trap_pc  = {$urandom, $urandom};
            run_model(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
